// File: rtl/gpu_fetch_unit.sv
// Instruction fetch stage: direct-mapped single-instruction cache in front of
// instruction memory, stalling the SIMT core through core_en on a miss.

package gpu_fetch_pkg;

  localparam logic [7:0] OP_ADD = 8'h01;

  // Decoded instruction word as delivered by instruction memory.
  typedef struct packed {
    logic [7:0]  opcode;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [11:0] imm;
  } instruction_t;

endpackage

module gpu_fetch_unit
  import gpu_fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned CACHE_LINES = 16,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic                  flush,
  output instruction_t          instr_out,
  output logic                  instr_valid,
  output logic                  core_en,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  instruction_t          imem_rsp_data,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  localparam int unsigned IDX_W = $clog2(CACHE_LINES);
  localparam int unsigned TAG_W = ADDR_WIDTH - IDX_W;

  typedef enum logic [1:0] {
    S_RUN,
    S_REQ,
    S_WAIT
  } state_t;

  state_t state, state_next;

  logic [CACHE_LINES-1:0] line_valid;
  logic [TAG_W-1:0]       tag_mem  [CACHE_LINES];
  instruction_t           data_mem [CACHE_LINES];

  logic [ADDR_WIDTH-1:0]  miss_addr;
  logic                   flush_pending;

  logic [IDX_W-1:0]       pc_idx;
  logic [TAG_W-1:0]       pc_tag;
  logic [IDX_W-1:0]       miss_idx;
  logic [TAG_W-1:0]       miss_tag;

  logic                   hit_c;
  logic                   miss_c;
  logic                   fill_c;

  assign pc_idx   = pc_in[IDX_W-1:0];
  assign pc_tag   = pc_in[ADDR_WIDTH-1:IDX_W];
  assign miss_idx = miss_addr[IDX_W-1:0];
  assign miss_tag = miss_addr[ADDR_WIDTH-1:IDX_W];

  // Zero-latency lookup; a flush or reset forces the cycle to look like a miss.
  always_comb begin
    hit_c = 1'b0;
    if (!rst && state == S_RUN && !flush) begin
      hit_c = line_valid[pc_idx] && (tag_mem[pc_idx] == pc_tag);
    end
  end

  assign instr_out     = data_mem[pc_idx];
  assign instr_valid   = hit_c;
  assign core_en       = hit_c;
  assign imem_req_addr = miss_addr;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus miss/fill strobes.
  always_comb begin
    state_next = state;
    miss_c     = 1'b0;
    fill_c     = 1'b0;
    case (state)
      S_RUN: begin
        if (!flush && !hit_c) begin
          state_next = S_REQ;
          miss_c     = 1'b1;
        end
      end
      S_REQ: begin
        if (imem_req_ready) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          state_next = S_RUN;
          fill_c     = !flush && !flush_pending;
        end
      end
      default: state_next = S_RUN;
    endcase
  end

  // Miss address, registered request valid and the discard-fill flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      miss_addr      <= '0;
      imem_req_valid <= 1'b0;
      flush_pending  <= 1'b0;
    end else begin
      if (miss_c) begin
        miss_addr <= pc_in;
      end
      imem_req_valid <= (state_next == S_REQ);
      if (state_next == S_RUN) begin
        flush_pending <= 1'b0;
      end else if (flush) begin
        flush_pending <= 1'b1;
      end
    end
  end

  // Valid bits: flush beats a same-cycle fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_valid <= '0;
    end else if (flush) begin
      line_valid <= '0;
    end else if (fill_c) begin
      line_valid[miss_idx] <= 1'b1;
    end
  end

  // Tag and data storage need no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (fill_c) begin
      tag_mem[miss_idx]  <= miss_tag;
      data_mem[miss_idx] <= imem_rsp_data;
    end
  end

  // Saturating hit / miss performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_c && hit_count != '1) begin
        hit_count <= hit_count + CNT_WIDTH'(1);
      end
      if (miss_c && miss_count != '1) begin
        miss_count <= miss_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_gpu_fetch_unit.sv
// Randomized self-checking bench for gpu_fetch_unit against a transaction-level
// cache model; a second CNT_WIDTH=4 instance in lockstep exercises saturation.

module tb_gpu_fetch_unit;
  import gpu_fetch_pkg::*;

  logic         clk;
  logic         rst;
  logic [15:0]  pc_in;
  logic         flush;
  instruction_t instr_out;
  logic         instr_valid;
  logic         core_en;
  logic         imem_req_valid;
  logic         imem_req_ready;
  logic [15:0]  imem_req_addr;
  logic         imem_rsp_valid;
  instruction_t imem_rsp_data;
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;

  instruction_t s_instr_out;
  logic         s_instr_valid;
  logic         s_core_en;
  logic         s_req_valid;
  logic [15:0]  s_req_addr;
  logic [3:0]   s_hit_count;
  logic [3:0]   s_miss_count;

  int checks;
  int errors;

  // Model: which full address each line holds (-1 = empty) and event counts.
  int cached [16];
  int exp_hits;
  int exp_misses;

  gpu_fetch_unit #(.ADDR_WIDTH(16), .CACHE_LINES(16), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .flush(flush),
    .instr_out(instr_out), .instr_valid(instr_valid), .core_en(core_en),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .hit_count(hit_count), .miss_count(miss_count)
  );

  gpu_fetch_unit #(.ADDR_WIDTH(16), .CACHE_LINES(16), .CNT_WIDTH(4)) dut_s (
    .clk(clk), .rst(rst), .pc_in(pc_in), .flush(flush),
    .instr_out(s_instr_out), .instr_valid(s_instr_valid), .core_en(s_core_en),
    .imem_req_valid(s_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(s_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .hit_count(s_hit_count), .miss_count(s_miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Instruction memory contents: unique per address, address 0 holds an ADD.
  function automatic instruction_t mem_word(input logic [15:0] a);
    logic [31:0] w;
    w = {8'(a * 16'd7) + OP_ADD, a[3:0], a[7:4], a[11:8], a[15:12] ^ 4'h5, a[7:0]};
    return instruction_t'(w);
  endfunction

  function automatic int sat4(input int x);
    return (x > 15) ? 15 : x;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) cached[i] = -1;
  endtask

  task automatic check_counters(input string where);
    check({where, "_hit_count"}, 32'(hit_count), 32'(exp_hits));
    check({where, "_miss_count"}, 32'(miss_count), 32'(exp_misses));
    check({where, "_sat_hit"}, 32'(s_hit_count), 32'(sat4(exp_hits)));
    check({where, "_sat_miss"}, 32'(s_miss_count), 32'(sat4(exp_misses)));
  endtask

  // One fetch of pc, playing the memory side. mode 0: plain, 1: flush with the
  // response, 2: flush on the first request cycle. Called at posedge+1.
  task automatic do_fetch(input logic [15:0] pc, input int rdy_dly, input int rsp_dly,
                          input int mode_in);
    bit hit_exp, in_wait, flushed, rsp_now, rdy_now;
    int hs, req_cnt, wait_cnt, exp_stall, exp_hs, base, mode;
    hit_exp  = (cached[pc[3:0]] == int'(pc));
    mode     = hit_exp ? 0 : mode_in;
    base     = 3 + rdy_dly + rsp_dly;
    exp_stall = hit_exp ? 0 : ((mode != 0) ? 2 * base : base);
    exp_hs   = hit_exp ? 0 : ((mode != 0) ? 2 : 1);
    in_wait  = 0; flushed = 0; hs = 0; req_cnt = 0; wait_cnt = 0;
    pc_in    = pc;
    for (int cyc = 0; cyc <= exp_stall; cyc++) begin
      flush   = 1'b0;
      rsp_now = 1'b0;
      if (imem_req_valid) rdy_now = (req_cnt >= rdy_dly);
      else                rdy_now = 1'($urandom_range(0, 1));
      imem_req_ready = rdy_now;
      if (in_wait) begin
        rsp_now        = (wait_cnt == rsp_dly);
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = mem_word(pc);
        if (mode == 1 && !flushed && rsp_now) begin
          flush = 1'b1; flushed = 1;
        end
      end else begin
        imem_rsp_valid = 1'($urandom_range(0, 1));
        imem_rsp_data  = ~mem_word(pc);
      end
      if (mode == 2 && !flushed && imem_req_valid && req_cnt == 0) begin
        flush = 1'b1; flushed = 1;
      end
      @(negedge clk);
      check("instr_valid", 32'(instr_valid), 32'(cyc == exp_stall));
      check("core_en", 32'(core_en), 32'(cyc == exp_stall));
      if (cyc == exp_stall) begin
        check("instr_out", 32'(instr_out), 32'(mem_word(pc)));
        check("req_idle_on_hit", 32'(imem_req_valid), 32'd0);
      end
      if (cyc == 0) check("req_idle_first", 32'(imem_req_valid), 32'd0);
      if (rsp_now) begin
        in_wait = 0; wait_cnt = 0;
      end else if (in_wait) begin
        wait_cnt++;
      end
      if (imem_req_valid) begin
        check("req_addr", 32'(imem_req_addr), 32'(pc));
        if (rdy_now) begin
          hs++; req_cnt = 0; in_wait = 1;
        end else begin
          req_cnt++;
        end
      end
      @(posedge clk); #1;
    end
    check("handshakes", 32'(hs), 32'(exp_hs));
    if (mode != 0) model_clear();
    if (!hit_exp) begin
      cached[pc[3:0]] = int'(pc);
      exp_misses += (mode != 0) ? 2 : 1;
    end
    exp_hits++;
    check_counters("fetch");
  endtask

  // One flush cycle while idle in RUN.
  task automatic do_flush();
    pc_in          = 16'($urandom_range(0, 63));
    flush          = 1'b1;
    imem_req_ready = 1'($urandom_range(0, 1));
    imem_rsp_valid = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("flush_no_hit", 32'(instr_valid), 32'd0);
    check("flush_no_req", 32'(imem_req_valid), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    model_clear();
  endtask

  initial begin
    logic [15:0] pc;
    int r;
    bit got_hs;
    checks = 0; errors = 0; exp_hits = 0; exp_misses = 0;
    model_clear();
    rst = 1'b1; pc_in = '0; flush = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;

    // Reset state.
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_core_en", 32'(core_en), 32'd0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", 32'(imem_req_addr), 32'd0);
    check_counters("rst");
    @(posedge clk); #1;
    rst = 1'b0;

    // Cold miss on 0 with immediate ready and a 1-cycle response, then holds.
    do_fetch(16'h0000, 0, 0, 0);
    check("cold_opcode", 32'(instr_out.opcode), 32'(OP_ADD));
    for (int i = 0; i < 5; i++) do_fetch(16'h0000, 0, 0, 0);

    // Ready held low for 4 cycles.
    do_fetch(16'h0003, 4, 0, 0);
    do_fetch(16'h0003, 0, 0, 0);

    // Conflict eviction on line 0.
    do_flush();
    do_fetch(16'h0000, 0, 1, 0);
    do_fetch(16'h0010, 1, 0, 0);
    do_fetch(16'h0000, 0, 0, 0);

    // Flush coincident with the response, then flush during the request.
    do_fetch(16'h0025, 1, 2, 1);
    do_fetch(16'h0031, 2, 1, 2);

    // 19 hits saturate the 4-bit counter.
    for (int i = 0; i < 19; i++) do_fetch(16'h0031, 0, 0, 0);
    check("sat_hit_all_ones", 32'(s_hit_count), 32'hF);

    // Random traffic.
    for (int i = 0; i < 200; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 8) begin
        do_flush();
      end else begin
        pc = 16'($urandom_range(0, 47));
        if (r % 5 == 0) pc = pc ^ 16'hA000;
        do_fetch(pc, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 (r >= 90) ? (r % 2) + 1 : 0);
      end
    end

    // Reset while waiting for a response.
    do_flush();
    pc_in = 16'h0077; imem_rsp_valid = 1'b0; got_hs = 0;
    for (int i = 0; i < 10 && !got_hs; i++) begin
      imem_req_ready = imem_req_valid;
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) got_hs = 1;
      @(posedge clk); #1;
    end
    check("rst_test_handshake", 32'(got_hs), 32'd1);
    imem_req_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    exp_hits = 0; exp_misses = 0;
    model_clear();
    check("midrst_instr_valid", 32'(instr_valid), 32'd0);
    check("midrst_req_valid", 32'(imem_req_valid), 32'd0);
    check("midrst_req_addr", 32'(imem_req_addr), 32'd0);
    check_counters("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    do_fetch(16'h0077, 0, 0, 0);
    do_fetch(16'h0077, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
